// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset controller: FSM states, datapath
// select codes, DP command codes and the condition-check function.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_HALT
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_MOV = 3'b100;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [3:0] COND_AL = 4'b1110;

    // flags is {N,Z,C,V}; encoding 1111 is treated as "never".
    function automatic logic condcheck(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v, ge;
        {n, z, c, v} = flags;
        ge = (n == v);
        case (cond)
            4'b0000: condcheck = z;
            4'b0001: condcheck = ~z;
            4'b0010: condcheck = c;
            4'b0011: condcheck = ~c;
            4'b0100: condcheck = n;
            4'b0101: condcheck = ~n;
            4'b0110: condcheck = v;
            4'b0111: condcheck = ~v;
            4'b1000: condcheck = c & ~z;
            4'b1001: condcheck = ~c | z;
            4'b1010: condcheck = ge;
            4'b1011: condcheck = ~ge;
            4'b1100: condcheck = ~z & ge;
            4'b1101: condcheck = z | ~ge;
            4'b1110: condcheck = 1'b1;
            default: condcheck = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] alu_decode(input logic [3:0] cmd);
        case (cmd)
            CMD_ADD: alu_decode = ALU_ADD;
            CMD_SUB: alu_decode = ALU_SUB;
            CMD_CMP: alu_decode = ALU_SUB;
            CMD_AND: alu_decode = ALU_AND;
            CMD_ORR: alu_decode = ALU_ORR;
            CMD_MOV: alu_decode = ALU_MOV;
            default: alu_decode = ALU_ADD;
        endcase
    endfunction

    // Only arithmetic commands produce meaningful carry/overflow.
    function automatic logic cmd_arith(input logic [3:0] cmd);
        cmd_arith = (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP);
    endfunction

endpackage

// File: rtl/cond_unit.sv
// Condition unit: NZCV flag register, per-instruction condition latch and
// gating of flag writes by the latched condition.
module cond_unit
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic       cond_latch,
    input  logic       flag_w_nz,
    input  logic       flag_w_cv,
    output logic       condex
);

    logic [3:0] flags_reg;
    logic       condex_reg;
    logic [1:0] flag_wen;

    // Index 1 is the NZ pair, index 0 the CV pair.
    assign flag_wen = {flag_w_nz, flag_w_cv} & {2{condex_reg}};
    assign condex   = condex_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            condex_reg <= 1'b0;
        end else if (cond_latch) begin
            condex_reg <= condcheck(Cond, flags_reg);
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_flag_pair
            always_ff @(posedge clk) begin
                if (reset) begin
                    flags_reg[2*gi +: 2] <= 2'b00;
                end else if (flag_wen[gi]) begin
                    flags_reg[2*gi +: 2] <= ALUFlags[2*gi +: 2];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control FSM and datapath select/enable decode.
// Optional MC_CTRL_UNDEF_TRAP_EN: undefined opcode (Op=11) traps into HALT.
module multicycle_controller
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       MemReq,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [2:0] ALUControl,
    output logic       Halted
);

    state_t     state_reg, state_next;
    logic       condex;
    logic       cond_latch;
    logic       flag_w_nz;
    logic       flag_w_cv;
    logic [3:0] cmd;
    logic       i_bit;
    logic       s_bit;
    logic       rd_pc;

    assign cmd   = Funct[4:1];
    assign i_bit = Funct[5];
    assign s_bit = Funct[0];
    assign rd_pc = (Rd == 4'hF);

    cond_unit u_cond_unit (
        .clk        (clk),
        .reset      (reset),
        .Cond       (Cond),
        .ALUFlags   (ALUFlags),
        .cond_latch (cond_latch),
        .flag_w_nz  (flag_w_nz),
        .flag_w_cv  (flag_w_cv),
        .condex     (condex)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cond_latch = 1'b0;
        flag_w_nz  = 1'b0;
        flag_w_cv  = 1'b0;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        MemReq     = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REG;
        ImmSrc     = IMM_DP;
        RegSrc     = 2'b00;
        ALUControl = ALU_ADD;
        Halted     = 1'b0;

        // Outputs are held quiet for the whole reset cycle, whatever state was active.
        if (!reset) begin
            case (state_reg)
                S_FETCH: begin
                    MemReq    = 1'b1;
                    ALUSrcA   = 1'b1;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALURESULT;
                    IRWrite   = MemReady;
                    PCWrite   = MemReady;
                    if (MemReady) begin
                        state_next = S_DECODE;
                    end
                end

                S_DECODE: begin
                    // PC+4 on the ALU here lets R15 read as PC+8.
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = SRCB_FOUR;
                    ResultSrc  = RES_ALURESULT;
                    cond_latch = 1'b1;
                    case (Op)
                        OP_DP:   state_next = i_bit ? S_EXECI : S_EXECR;
                        OP_MEM:  state_next = S_MEMADR;
                        OP_BR:   state_next = S_BRANCH;
`ifdef MC_CTRL_UNDEF_TRAP_EN
                        default: state_next = S_HALT;
`else
                        default: state_next = S_FETCH;
`endif
                    endcase
                end

                S_MEMADR: begin
                    ALUSrcB    = SRCB_IMM;
                    ImmSrc     = IMM_MEM;
                    ALUControl = ALU_ADD;
                    state_next = s_bit ? S_MEMRD : S_MEMWR;
                end

                S_MEMRD: begin
                    MemReq = 1'b1;
                    AdrSrc = 1'b1;
                    if (MemReady) begin
                        state_next = S_MEMWB;
                    end
                end

                S_MEMWB: begin
                    ResultSrc  = RES_DATA;
                    RegWrite   = condex;
                    PCWrite    = condex & rd_pc;
                    state_next = S_FETCH;
                end

                S_MEMWR: begin
                    AdrSrc = 1'b1;
                    RegSrc = 2'b10;
                    // A failed-condition store never touches memory.
                    if (condex) begin
                        MemReq   = 1'b1;
                        MemWrite = 1'b1;
                        if (MemReady) begin
                            state_next = S_FETCH;
                        end
                    end else begin
                        state_next = S_FETCH;
                    end
                end

                S_EXECR, S_EXECI: begin
                    ALUSrcB    = (state_reg == S_EXECI) ? SRCB_IMM : SRCB_REG;
                    ImmSrc     = IMM_DP;
                    ALUControl = alu_decode(cmd);
                    flag_w_nz  = s_bit;
                    flag_w_cv  = s_bit & cmd_arith(cmd);
                    state_next = (cmd == CMD_CMP) ? S_FETCH : S_ALUWB;
                end

                S_ALUWB: begin
                    ResultSrc  = RES_ALUOUT;
                    RegWrite   = condex;
                    PCWrite    = condex & rd_pc;
                    state_next = S_FETCH;
                end

                S_BRANCH: begin
                    RegSrc     = 2'b01;
                    ALUSrcB    = SRCB_IMM;
                    ImmSrc     = IMM_BR;
                    ResultSrc  = RES_ALURESULT;
                    PCWrite    = condex;
                    state_next = S_FETCH;
                end

                S_HALT: begin
`ifdef MC_CTRL_UNDEF_TRAP_EN
                    Halted     = 1'b1;
                    state_next = S_HALT;
`else
                    state_next = S_FETCH;
`endif
                end

                default: begin
                    state_next = S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized instruction-level bench for multicycle_controller with an
// instruction-sequencing reference model and NZCV flag model.
module tb_multicycle_controller;

    typedef struct packed {
        logic       pcw;
        logic       adrsrc;
        logic       memw;
        logic       memreq;
        logic       irw;
        logic       regw;
        logic [1:0] ressrc;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] imm;
        logic [1:0] regsrc;
        logic [2:0] aluc;
        logic       halted;
    } ctl_t;

    localparam int C_DPI = 0, C_DPR = 1, C_LDR = 2, C_STR = 3, C_B = 4, C_UND = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond, Rd, ALUFlags;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       MemReady;
    logic       PCWrite, AdrSrc, MemWrite, MemReq, IRWrite, RegWrite, ALUSrcA, Halted;
    logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [2:0] ALUControl;
    ctl_t       obs;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] mflags   = 4'b0000;
    logic [3:0] cmds [6] = '{4'b0100, 4'b0010, 4'b1010, 4'b0000, 4'b1100, 4'b1101};

    multicycle_controller dut (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .MemReq(MemReq), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .RegSrc(RegSrc), .ALUControl(ALUControl), .Halted(Halted)
    );

    always #5 clk = ~clk;

    assign obs = {PCWrite, AdrSrc, MemWrite, MemReq, IRWrite, RegWrite, ResultSrc, ALUSrcA,
                  ALUSrcB, ImmSrc, RegSrc, ALUControl, Halted};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: observed %h, expected %h", tag, got, want);
        end
    endtask

    // Checks one cycle at the falling edge, then steps to just after the next rising edge.
    task automatic cyc(input string tag, input ctl_t e, input ctl_t m);
        logic [18:0] ov, ev, mv;
        @(negedge clk);
        ov = obs;
        ev = e;
        mv = m;
        check(tag, 32'(ov & mv), 32'(ev & mv));
        @(posedge clk);
        #1;
    endtask

    function automatic ctl_t en_mask();
        ctl_t m;
        m        = '0;
        m.pcw    = 1'b1;
        m.memw   = 1'b1;
        m.memreq = 1'b1;
        m.irw    = 1'b1;
        m.regw   = 1'b1;
        m.halted = 1'b1;
        return m;
    endfunction

    // ARM condition semantics: even codes test a predicate, odd codes its negation.
    function automatic logic condok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, r;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cy;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cy && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return c[0] ? !r : r;
    endfunction

    function automatic logic [2:0] alu_of(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return 3'b000;
            4'b0010: return 3'b001;
            4'b1010: return 3'b001;
            4'b0000: return 3'b010;
            4'b1100: return 3'b011;
            4'b1101: return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    task automatic reset_cycle(input string tag);
        ctl_t e, m;
        reset    = 1'b1;
        MemReady = 1'b0;
        e = '0;
        m = en_mask();
        cyc(tag, e, m);
        reset  = 1'b0;
        mflags = 4'b0000;
    endtask

    task automatic run_instr(input int cls, input logic [3:0] cond, input logic [3:0] cmd,
                             input logic s, input logic [3:0] rd, input int fw, input int mw,
                             input int xflags, input bit rst_mem);
        ctl_t e, m;
        logic ce;
        logic [3:0] af;
        Cond  = cond;
        Rd    = rd;
        Op    = (cls <= C_DPR) ? 2'b00 : (cls <= C_STR) ? 2'b01 : (cls == C_B) ? 2'b10 : 2'b11;
        Funct = {cls == C_DPI, cmd, (cls == C_LDR) ? 1'b1 : (cls == C_STR) ? 1'b0 : s};

        for (int i = 0; i <= fw; i++) begin
            MemReady = (i == fw);
            ALUFlags = 4'($urandom);
            e = '0; m = en_mask();
            e.memreq = 1'b1; e.irw = MemReady; e.pcw = MemReady;
            e.srca = 1'b1; e.srcb = 2'b10; e.ressrc = 2'b10;
            m.adrsrc = 1'b1; m.srca = 1'b1; m.srcb = 2'b11; m.ressrc = 2'b11;
            cyc("fetch", e, m);
        end

        MemReady = 1'($urandom);
        e = '0; m = en_mask();
        e.srca = 1'b1; e.srcb = 2'b10; e.ressrc = 2'b10;
        m.srca = 1'b1; m.srcb = 2'b11; m.ressrc = 2'b11;
        cyc("decode", e, m);
        ce = condok(cond, mflags);

        case (cls)
            C_DPI, C_DPR: begin
                af = (xflags >= 0) ? 4'(xflags) : 4'($urandom);
                ALUFlags = af;
                MemReady = 1'($urandom);
                e = '0; m = en_mask();
                e.srcb = (cls == C_DPI) ? 2'b01 : 2'b00; m.srcb = 2'b11;
                if (cls == C_DPI) m.imm = 2'b11;
                e.aluc = alu_of(cmd); m.aluc = 3'b111;
                cyc("exec", e, m);
                if (s && ce) begin
                    mflags[3:2] = af[3:2];
                    if (cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b1010) mflags[1:0] = af[1:0];
                end
                if (cmd != 4'b1010) begin
                    ALUFlags = 4'($urandom);
                    e = '0; m = en_mask();
                    m.ressrc = 2'b11;
                    e.regw = ce; e.pcw = ce && (rd == 4'hF);
                    cyc("aluwb", e, m);
                end
            end
            C_LDR, C_STR: begin
                MemReady = 1'($urandom);
                e = '0; m = en_mask();
                e.srcb = 2'b01; e.imm = 2'b01; m.srcb = 2'b11; m.imm = 2'b11; m.aluc = 3'b111;
                cyc("memadr", e, m);
                if (cls == C_LDR) begin
                    for (int i = 0; i <= mw; i++) begin
                        MemReady = (i == mw);
                        e = '0; m = en_mask();
                        e.memreq = 1'b1; e.adrsrc = 1'b1; m.adrsrc = 1'b1;
                        cyc("memrd", e, m);
                    end
                    MemReady = 1'($urandom);
                    e = '0; m = en_mask();
                    e.ressrc = 2'b01; m.ressrc = 2'b11;
                    e.regw = ce; e.pcw = ce && (rd == 4'hF);
                    cyc("memwb", e, m);
                end else if (rst_mem) begin
                    reset_cycle("memwr_reset");
                end else if (ce) begin
                    for (int i = 0; i <= mw; i++) begin
                        MemReady = (i == mw);
                        e = '0; m = en_mask();
                        e.memreq = 1'b1; e.memw = 1'b1; e.adrsrc = 1'b1; m.adrsrc = 1'b1;
                        e.regsrc = 2'b10; m.regsrc = 2'b10;
                        cyc("memwr", e, m);
                    end
                end else begin
                    MemReady = 1'($urandom);
                    e = '0; m = en_mask();
                    cyc("memwr_skip", e, m);
                end
            end
            C_B: begin
                MemReady = 1'($urandom);
                e = '0; m = en_mask();
                e.regsrc = 2'b01; m.regsrc = 2'b01;
                e.srcb = 2'b01; m.srcb = 2'b11;
                e.imm = 2'b10; m.imm = 2'b11;
                e.ressrc = 2'b10; m.ressrc = 2'b11;
                e.pcw = ce;
                cyc("branch", e, m);
            end
            default: begin
`ifdef MC_CTRL_UNDEF_TRAP_EN
                for (int i = 0; i < 3; i++) begin
                    MemReady = 1'($urandom);
                    e = '0; m = en_mask();
                    e.halted = 1'b1;
                    cyc("halt", e, m);
                end
                reset_cycle("halt_reset");
`endif
            end
        endcase
    endtask

    initial begin
        reset    = 1'b1;
        Cond     = 4'h0;
        Op       = 2'b00;
        Funct    = 6'h00;
        Rd       = 4'h0;
        ALUFlags = 4'h0;
        MemReady = 1'b1;
        @(posedge clk);
        #1;
        reset_cycle("reset0");
        reset_cycle("reset1");

        // ADD R1,R2,#5
        run_instr(C_DPI, 4'hE, 4'b0100, 1'b0, 4'h1, 0, 0, -1, 1'b0);
        // SUBS with Z=1,C=1 then BNE (not taken)
        run_instr(C_DPR, 4'hE, 4'b0010, 1'b1, 4'h2, 0, 0, 4'b0110, 1'b0);
        run_instr(C_B, 4'h1, 4'h0, 1'b0, 4'h0, 0, 0, -1, 1'b0);
        // BEQ taken on the same flags
        run_instr(C_B, 4'h0, 4'h0, 1'b0, 4'h0, 1, 0, -1, 1'b0);
        // LDR with three wait cycles
        run_instr(C_LDR, 4'hE, 4'h0, 1'b0, 4'h4, 0, 3, -1, 1'b0);
        // MOV PC,R3
        run_instr(C_DPR, 4'hE, 4'b1101, 1'b0, 4'hF, 0, 0, -1, 1'b0);
        // Undefined opcode
        run_instr(C_UND, 4'hE, 4'h0, 1'b0, 4'h0, 0, 0, -1, 1'b0);
        // Set Z, then reset during a stalled store; BEQ must see cleared flags
        run_instr(C_DPR, 4'hE, 4'b1010, 1'b1, 4'h0, 0, 0, 4'b0100, 1'b0);
        run_instr(C_STR, 4'hE, 4'h0, 1'b0, 4'h5, 0, 0, -1, 1'b1);
        run_instr(C_B, 4'h0, 4'h0, 1'b0, 4'h0, 0, 0, -1, 1'b0);

        for (int k = 0; k < 300; k++) begin
            int         cls;
            logic [3:0] cond;
            cls  = int'($urandom_range(0, 5));
            cond = $urandom_range(0, 1) ? 4'hE : 4'($urandom);
            run_instr(cls, cond, cmds[$urandom_range(0, 5)], 1'($urandom), 4'($urandom),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
